// File: rtl/serial_to_parallel_converter_if.sv
// Bit-serial input and word-parallel output handshakes of the serial-to-parallel converter.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid && ready are both high.
interface serial_to_parallel_converter_if #(
  parameter int N = 8
) ();
  logic         ser_data;
  logic         ser_valid;
  logic         ser_ready;
  logic [N-1:0] par_data;
  logic         par_valid;
  logic         par_ready;

  modport master (
    output ser_data, ser_valid, par_ready,
    input  ser_ready, par_data, par_valid
  );

  modport slave (
    input  ser_data, ser_valid, par_ready,
    output ser_ready, par_data, par_valid
  );
endinterface

// File: rtl/serial_to_parallel_converter.sv
// Assembles an LSB-first serial bit stream into N-bit words behind a one-word holding register,
// so assembly of the next word can continue while the consumer stalls.
module serial_to_parallel_converter #(
  parameter int N = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  serial_to_parallel_converter_if.slave bus,
  output logic [$clog2(N)-1:0]          o_dbg_count,
  output logic                          o_dbg_out_full
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // The oldest shifted bit is never read again, so only the upper N-1 bits are stored.
  logic [N-2:0]  r_shift, w_shift_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [N-1:0]  r_par_data, w_par_data_nxt;
  logic          r_out_full, w_out_full_nxt;

  logic [N-1:0]  w_word;
  logic          w_last;
  logic          w_ser_ready;
  logic          w_accept;
  logic          w_drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_count    <= '0;
      r_par_data <= '0;
      r_out_full <= 1'b0;
    end else begin
      r_shift    <= w_shift_nxt;
      r_count    <= w_count_nxt;
      r_par_data <= w_par_data_nxt;
      r_out_full <= w_out_full_nxt;
    end
  end

  always_comb begin
    w_shift_nxt    = r_shift;
    w_count_nxt    = r_count;
    w_par_data_nxt = r_par_data;
    w_out_full_nxt = r_out_full;
    if (w_drain) begin
      w_out_full_nxt = 1'b0;
    end
    if (flush) begin
      w_shift_nxt = '0;
      w_count_nxt = '0;
    end else if (w_accept) begin
      w_shift_nxt = w_word[N-1:1];
      if (w_last) begin
        // ser_ready guarantees the holding register is empty here, so no clash with drain.
        w_count_nxt    = '0;
        w_par_data_nxt = w_word;
        w_out_full_nxt = 1'b1;
      end else begin
        w_count_nxt = r_count + CW'(1);
      end
    end
  end

  always_comb begin
    w_word      = {bus.ser_data, r_shift};
    w_last      = (r_count == LAST);
    w_ser_ready = !(r_out_full && w_last);
    w_accept    = bus.ser_valid && w_ser_ready;
    w_drain     = r_out_full && bus.par_ready;
  end

  assign bus.ser_ready  = w_ser_ready;
  assign bus.par_valid  = r_out_full;
  assign bus.par_data   = r_par_data;
  assign o_dbg_count    = r_count;
  assign o_dbg_out_full = r_out_full;

  a_par_data_stable : assert property (@(posedge clk) disable iff (rst)
    (bus.par_valid && !bus.par_ready) |=> $stable(bus.par_data));

  a_count_range : assert property (@(posedge clk) r_count <= LAST);
endmodule

// File: tb/tb_serial_to_parallel_converter.sv
// Scoreboard bench: an N=8 converter for directed scenarios and an N=5 converter for throttled random traffic.
module tb_serial_to_parallel_converter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush8 = 1'b0;
  logic flush5 = 1'b0;
  logic [2:0] dbg_count8;
  logic [2:0] dbg_count5;
  logic       dbg_full8;
  logic       dbg_full5;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q8[$];
  logic [4:0] exp_q5[$];
  logic done5 = 1'b0;

  serial_to_parallel_converter_if #(.N(8)) if8 ();
  serial_to_parallel_converter_if #(.N(5)) if5 ();

  serial_to_parallel_converter #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .flush(flush8), .bus(if8.slave),
    .o_dbg_count(dbg_count8), .o_dbg_out_full(dbg_full8)
  );

  serial_to_parallel_converter #(.N(5)) u_dut5 (
    .clk(clk), .rst(rst), .flush(flush5), .bus(if5.slave),
    .o_dbg_count(dbg_count5), .o_dbg_out_full(dbg_full5)
  );

  // clock / reset
  always #5 clk = ~clk;

  // monitors: sample at negedge, i.e. the values the next rising edge will see
  logic       prev_v8 = 1'b0, prev_r8 = 1'b0;
  logic [7:0] prev_d8 = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v8 = 1'b0;
    end else begin
      if (prev_v8 && !prev_r8) begin
        n_vec++;
        if (if8.par_data !== prev_d8) begin
          n_err++;
          $display("FAIL stable8: par_data %h required %h", if8.par_data, prev_d8);
        end
      end
      if (if8.par_valid && if8.par_ready) begin
        n_vec++;
        if (exp_q8.size() == 0) begin
          n_err++;
          $display("FAIL word8: got %h, required no word", if8.par_data);
        end else begin
          logic [7:0] e;
          e = exp_q8.pop_front();
          if (if8.par_data !== e) begin
            n_err++;
            $display("FAIL word8: got %h required %h", if8.par_data, e);
          end
        end
      end
      prev_v8 = if8.par_valid;
      prev_r8 = if8.par_ready;
      prev_d8 = if8.par_data;
    end
  end

  logic       prev_v5 = 1'b0, prev_r5 = 1'b0;
  logic [4:0] prev_d5 = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v5 = 1'b0;
    end else begin
      n_vec++;
      if (dbg_count5 > 3'd4) begin
        n_err++;
        $display("FAIL count5: count %0d required <= 4", dbg_count5);
      end
      if (prev_v5 && !prev_r5) begin
        n_vec++;
        if (if5.par_data !== prev_d5) begin
          n_err++;
          $display("FAIL stable5: par_data %h required %h", if5.par_data, prev_d5);
        end
      end
      if (if5.par_valid && if5.par_ready) begin
        n_vec++;
        if (exp_q5.size() == 0) begin
          n_err++;
          $display("FAIL word5: got %h, required no word", if5.par_data);
        end else begin
          logic [4:0] e;
          e = exp_q5.pop_front();
          if (if5.par_data !== e) begin
            n_err++;
            $display("FAIL word5: got %h required %h", if5.par_data, e);
          end
        end
      end
      prev_v5 = if5.par_valid;
      prev_r5 = if5.par_ready;
      prev_d5 = if5.par_data;
    end
  end

  // drivers: entered and left at #1 after a rising edge; the bit is accepted on the last edge waited
  task automatic send_bit8(input logic b);
    int t;
    t = 0;
    if8.ser_data  = b;
    if8.ser_valid = 1'b1;
    while (!if8.ser_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout8: ser_ready 0 required 1");
    end
    @(posedge clk); #1;
    if8.ser_valid = 1'b0;
  endtask

  task automatic send_bits8(input logic [7:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) send_bit8(w[i]);
  endtask

  task automatic send_bit5(input logic b);
    int t;
    t = 0;
    if5.ser_data  = b;
    if5.ser_valid = 1'b1;
    while (!if5.ser_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout5: ser_ready 0 required 1");
    end
    @(posedge clk); #1;
    if5.ser_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec += 3;
    if (if8.par_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: %b required 0", if8.par_valid); end
    if (if8.par_data !== 8'h00) begin n_err++; $display("FAIL reset_data: %h required 00", if8.par_data); end
    if (if8.ser_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: %b required 1", if8.ser_ready); end
  endtask

  task automatic test_basic;
    logic [7:0] bits;
    bits = 8'b0100_1101;  // sent LSB first: 1,0,1,1,0,0,1,0
    if8.par_ready = 1'b1;
    exp_q8.push_back(8'h4D);
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (if8.ser_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: bit %0d ser_ready %b required 1", i, if8.ser_ready); end
      send_bit8(bits[i]);
    end
    n_vec += 2;
    if (if8.par_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency: par_valid %b required 1", if8.par_valid); end
    if (if8.par_data !== 8'h4D) begin n_err++; $display("FAIL basic_data: %h required 4d", if8.par_data); end
    @(posedge clk); #1;
    n_vec++;
    if (if8.par_valid !== 1'b0) begin n_err++; $display("FAIL basic_pulse: par_valid %b required 0", if8.par_valid); end
  endtask

  task automatic test_stall;
    logic [7:0] w2;
    w2 = 8'h3C;
    if8.par_ready = 1'b0;
    exp_q8.push_back(8'hA5);
    exp_q8.push_back(8'h3C);
    send_bits8(8'hA5, 0, 7);
    send_bits8(w2, 0, 6);
    if8.ser_data  = w2[7];
    if8.ser_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_vec += 4;
    if (if8.ser_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: %b required 0", if8.ser_ready); end
    if (if8.par_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: %b required 1", if8.par_valid); end
    if (if8.par_data !== 8'hA5) begin n_err++; $display("FAIL stall_hold: %h required a5", if8.par_data); end
    if (dbg_count8 !== 3'd7) begin n_err++; $display("FAIL stall_count: %0d required 7", dbg_count8); end
    if8.par_ready = 1'b1;
    @(posedge clk); #1;
    n_vec += 2;
    if (if8.par_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain: par_valid %b required 0", if8.par_valid); end
    if (if8.ser_ready !== 1'b1) begin n_err++; $display("FAIL stall_release: ser_ready %b required 1", if8.ser_ready); end
    @(posedge clk); #1;
    if8.ser_valid = 1'b0;
    n_vec += 2;
    if (if8.par_valid !== 1'b1) begin n_err++; $display("FAIL stall_second_valid: %b required 1", if8.par_valid); end
    if (if8.par_data !== 8'h3C) begin n_err++; $display("FAIL stall_second_data: %h required 3c", if8.par_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_drain_and_accept;
    logic [7:0] w2;
    w2 = 8'hC3;
    if8.par_ready = 1'b0;
    exp_q8.push_back(8'h5A);
    send_bits8(8'h5A, 0, 7);
    exp_q8.push_back(w2);
    send_bits8(w2, 0, 2);
    n_vec += 2;
    if (dbg_full8 !== 1'b1) begin n_err++; $display("FAIL da_full: %b required 1", dbg_full8); end
    if (dbg_count8 !== 3'd3) begin n_err++; $display("FAIL da_count3: %0d required 3", dbg_count8); end
    if8.par_ready = 1'b1;
    send_bit8(w2[3]);
    n_vec += 2;
    if (if8.par_valid !== 1'b0) begin n_err++; $display("FAIL da_drain: par_valid %b required 0", if8.par_valid); end
    if (dbg_count8 !== 3'd4) begin n_err++; $display("FAIL da_count4: %0d required 4", dbg_count8); end
    send_bits8(w2, 4, 7);
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    if8.par_ready = 1'b1;
    send_bits8(8'h1F, 0, 4);
    flush8        = 1'b1;
    if8.ser_data  = 1'b1;
    if8.ser_valid = 1'b1;
    @(posedge clk); #1;
    flush8        = 1'b0;
    if8.ser_valid = 1'b0;
    n_vec += 2;
    if (dbg_count8 !== 3'd0) begin n_err++; $display("FAIL flush_count: %0d required 0", dbg_count8); end
    if (if8.par_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: %b required 0", if8.par_valid); end
    exp_q8.push_back(8'hF0);
    send_bits8(8'hF0, 0, 7);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_hold;
    if8.par_ready = 1'b0;
    send_bits8(8'h77, 0, 7);  // lost to the reset below, so never expected
    send_bits8(8'h12, 0, 5);
    n_vec += 2;
    if (dbg_full8 !== 1'b1) begin n_err++; $display("FAIL rmh_full: %b required 1", dbg_full8); end
    if (dbg_count8 !== 3'd6) begin n_err++; $display("FAIL rmh_count: %0d required 6", dbg_count8); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec += 4;
    if (if8.par_valid !== 1'b0) begin n_err++; $display("FAIL rmh_valid: %b required 0", if8.par_valid); end
    if (if8.par_data !== 8'h00) begin n_err++; $display("FAIL rmh_data: %h required 00", if8.par_data); end
    if (if8.ser_ready !== 1'b1) begin n_err++; $display("FAIL rmh_ready: %b required 1", if8.ser_ready); end
    if (dbg_count8 !== 3'd0) begin n_err++; $display("FAIL rmh_count0: %0d required 0", dbg_count8); end
    if8.par_ready = 1'b1;
    exp_q8.push_back(8'h81);
    send_bits8(8'h81, 0, 7);
    repeat (2) begin @(posedge clk); #1; end
    n_vec++;
    if (exp_q8.size() != 0) begin n_err++; $display("FAIL q8_empty: %0d words left required 0", exp_q8.size()); end
  endtask

  task automatic test_random_n5;
    int t;
    fork
      begin
        for (int w = 0; w < 1000; w++) begin
          logic [4:0] wd;
          wd = 5'($urandom);
          exp_q5.push_back(wd);
          for (int i = 0; i < 5; i++) begin
            if5.ser_valid = 1'b0;
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            send_bit5(wd[i]);
          end
        end
        done5 = 1'b1;
      end
      begin
        while (!done5) begin
          @(posedge clk); #1;
          if5.par_ready = ($urandom_range(0, 3) != 0);
        end
        if5.par_ready = 1'b1;
      end
    join
    t = 0;
    while (exp_q5.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    n_vec++;
    if (exp_q5.size() != 0) begin n_err++; $display("FAIL q5_empty: %0d words left required 0", exp_q5.size()); end
  endtask

  initial begin
    if8.ser_data = 1'b0; if8.ser_valid = 1'b0; if8.par_ready = 1'b0;
    if5.ser_data = 1'b0; if5.ser_valid = 1'b0; if5.par_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_drain_and_accept();
    test_flush();
    test_reset_mid_hold();
    test_random_n5();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
